fp_result_monitor: RTL and testbench
====================================

FP_RESULT_MONITOR -- requirements
Module: fp_result_monitor

Interface
REQ-001 Parameter WIDTH, default 32, operand and result word width.
REQ-002 Parameter EXP_BITS, default 8, exponent field width.
REQ-003 Parameter MANT_BITS, default 23, mantissa field width; WIDTH SHALL equal 1+EXP_BITS+MANT_BITS.
REQ-004 Parameter DEPTH, default 4, result FIFO depth, power of two, minimum 2.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port in_valid  input  1  a, b, operation_select and result are valid this cycle.
REQ-008 Ports a, b  input  WIDTH  operands as driven to the add/sub unit.
REQ-009 Port operation_select  input  1  0 = add, 1 = subtract.
REQ-010 Port result  input  WIDTH  add/sub unit output for the current operands.
REQ-011 Port out_valid  output  1  FIFO head entry is valid.
REQ-012 Port out_ready  input  1  consumer accepts the head entry.
REQ-013 Ports out_a, out_b, out_result  output  WIDTH  captured words of the head entry.
REQ-014 Port out_op  output  1  captured operation_select of the head entry.
REQ-015 Ports sign_result 1, exp_result EXP_BITS, mantissa_result MANT_BITS  output  fields of out_result.
REQ-016 Port result_class  output  3  classification of out_result.
REQ-017 Port fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-018 Port fifo_full  output  1  fifo_count == DEPTH.
REQ-019 Port overflow_cnt  output  8  count of dropped entries, saturating.

Function
REQ-020 Stage 1 SHALL register a, b, operation_select, result and a stage-valid bit on each cycle; stage-valid = in_valid.
REQ-021 Stage 2 SHALL classify the stage-1 result and push {a, b, op, result, class} into the FIFO when stage-valid is 1.
REQ-022 Classes: 0 ZERO (exp 0, mant 0), 1 DENORM (exp 0, mant != 0), 2 NORMAL (exp neither 0 nor all-ones), 3 INF (exp all-ones, mant 0), 4 QNAN (exp all-ones, mant MSB 1), 5 SNAN (exp all-ones, mant MSB 0, mant != 0); 6 and 7 unused.
REQ-023 Sign SHALL NOT affect class; sign_result SHALL be out_result[WIDTH-1].
REQ-024 Latency: in_valid in cycle N with the FIFO empty SHALL give out_valid = 1 with that entry in cycle N+2.
REQ-025 FIFO SHALL be show-ahead: the head entry is on the out_* ports whenever out_valid = 1.
REQ-026 Pop SHALL occur on a cycle with out_valid = 1 and out_ready = 1; out_ready while empty SHALL be ignored.
REQ-027 Push SHALL be accepted when fifo_count < DEPTH or a pop occurs in the same cycle.
REQ-028 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-029 A push refused because the FIFO is full SHALL drop the entry and increment overflow_cnt, which holds at 255.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 When out_valid = 0, out_* and field outputs SHALL be 0 and result_class SHALL be ZERO.
REQ-032 The entry order in the FIFO SHALL match the input order; accepted entries SHALL never be lost or duplicated.

Reset
REQ-033 rst_n low SHALL immediately clear stage-valid, the pointers, fifo_count, overflow_cnt and all data registers to 0, with no clock edge required.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries; the first in_valid after rst_n goes high SHALL follow REQ-024.
REQ-035 After reset: out_valid = 0, fifo_full = 0, all outputs = 0.

Verification
REQ-036 a = b = 0x3f800000, op = 0, result = 0x40000000, FIFO empty -> at N+2: out_valid = 1, class NORMAL, sign 0, exp 0x80, mant 0.
REQ-037 Results 0x7fc00000, 0x7f800001, 0xff800000, 0x00000001, 0x80000000 in consecutive cycles -> classes QNAN, SNAN, INF (sign 1), DENORM, ZERO (sign 1), in that order.
REQ-038 out_ready = 0 and 6 consecutive in_valid -> first 4 entries kept, fifo_full = 1, overflow_cnt = 2.
REQ-039 FIFO full, out_ready = 1, in_valid held -> one pop and one push each cycle, fifo_count stays 4, overflow_cnt does not change.
REQ-040 rst_n pulsed low between clock edges with 3 entries stored -> fifo_count = 0, out_valid = 0 and overflow_cnt = 0 before the next edge.
REQ-041 300 entries dropped while full -> overflow_cnt = 255.

Source files
------------

// File: rtl/fp_result_monitor.sv
// Captures add/sub operands and results, classifies the result and queues it for a consumer.
// Latency: in_valid in cycle N reaches the out_* ports in cycle N+2 when the queue is empty.
// Backpressure: out_ready stalls the queue; entries arriving while the queue is full are dropped and counted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, a, b,
//   operation_select, result   observed add/sub transaction (0 = add, 1 = subtract)
//   out_valid, out_ready       show-ahead head-of-queue handshake
//   out_a, out_b, out_op,
//   out_result                 captured words of the head entry (0 when empty)
//   sign_result, exp_result,
//   mantissa_result            fields of out_result
//   result_class               0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 QNAN, 5 SNAN
//   fifo_count, fifo_full      queue occupancy
//   overflow_cnt               dropped entries, saturating at 255

// Generic show-ahead FIFO with a registered occupancy count.
// Latency: a push is visible on rd_dat the cycle after it is written.
// Backpressure: wr_rdy drops when full unless a pop frees a slot in the same cycle.
module fp_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_vld && rd_rdy;
    // A slot freed by a same-cycle pop can be refilled immediately.
    assign wr_rdy = (count != CW'(DEPTH)) || pop;
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of two, so the pointer wraps naturally
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module fp_result_monitor #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   operation_select,
    input  logic [WIDTH-1:0]       result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_op,
    output logic                   sign_result,
    output logic [EXP_BITS-1:0]    exp_result,
    output logic [MANT_BITS-1:0]   mantissa_result,
    output logic [2:0]             result_class,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic [7:0]             overflow_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
        logic [WIDTH-1:0] res;
        logic [2:0]       cls;
    } entry_t;

    localparam int EW = $bits(entry_t);

    // Stage 1: capture registers
    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_op;
    logic [WIDTH-1:0] s1_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= 1'b0;
            s1_res <= '0;
        end else begin
            s1_vld <= in_valid;
            s1_a   <= a;
            s1_b   <= b;
            s1_op  <= operation_select;
            s1_res <= result;
        end
    end

    // Stage 2: classify and push
    logic [EXP_BITS-1:0]  s1_exp;
    logic [MANT_BITS-1:0] s1_mant;
    logic [2:0]           s1_cls;

    assign s1_exp  = s1_res[WIDTH-2 -: EXP_BITS];
    assign s1_mant = s1_res[MANT_BITS-1:0];

    // Sign bit is deliberately ignored: -0 is ZERO, -inf is INF.
    always_comb begin
        s1_cls = CLS_NORMAL;
        if (s1_exp == '0) begin
            s1_cls = (s1_mant == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (&s1_exp) begin
            if (s1_mant == '0) begin
                s1_cls = CLS_INF;
            end else if (s1_mant[MANT_BITS-1]) begin
                s1_cls = CLS_QNAN;
            end else begin
                s1_cls = CLS_SNAN;
            end
        end
    end

    entry_t wr_ent;
    entry_t head;
    logic   wr_rdy;
    logic   head_vld;

    assign wr_ent = '{a: s1_a, b: s1_b, op: s1_op, res: s1_res, cls: s1_cls};

    fp_result_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (s1_vld),
        .wr_dat (wr_ent),
        .wr_rdy (wr_rdy),
        .rd_vld (head_vld),
        .rd_rdy (out_ready),
        .rd_dat (head),
        .count  (fifo_count)
    );

    // Drop counter; a push that coincides with a pop is never a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (s1_vld && !wr_rdy && (overflow_cnt != 8'hff)) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    // Outputs are forced to zero while the queue is empty so stale slots never leak.
    assign out_valid       = head_vld;
    assign out_a           = head_vld ? head.a   : '0;
    assign out_b           = head_vld ? head.b   : '0;
    assign out_op          = head_vld ? head.op  : 1'b0;
    assign out_result      = head_vld ? head.res : '0;
    assign result_class    = head_vld ? head.cls : CLS_ZERO;
    assign sign_result     = out_result[WIDTH-1];
    assign exp_result      = out_result[WIDTH-2 -: EXP_BITS];
    assign mantissa_result = out_result[MANT_BITS-1:0];
    assign fifo_full       = (fifo_count == CW'(DEPTH));
endmodule

// File: tb/tb_fp_result_monitor.sv
module tb_fp_result_monitor;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        operation_select = 1'b0;
    logic [31:0] result = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_result;
    logic        out_op;
    logic        sign_result;
    logic [7:0]  exp_result;
    logic [22:0] mantissa_result;
    logic [2:0]  result_class;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic [7:0]  overflow_cnt;

    int checks = 0;
    int errors = 0;

    fp_result_monitor #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .operation_select(operation_select), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_result(out_result), .out_op(out_op), .sign_result(sign_result),
        .exp_result(exp_result), .mantissa_result(mantissa_result),
        .result_class(result_class), .fifo_count(fifo_count), .fifo_full(fifo_full),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
    } ent_t;

    ent_t mq[$];
    ent_t m_cap;
    bit   m_cap_vld = 1'b0;
    int   m_ovf = 0;

    // Classification straight from the IEEE-754 field rules.
    function automatic int cls_of(input logic [31:0] r);
        int e;
        int m;
        e = int'((r >> 23) & 32'hff);
        m = int'(r & 32'h7fffff);
        if (e == 0)   return (m == 0) ? 0 : 1;
        if (e == 255) begin
            if (m == 0)         return 3;
            if (m >= 'h400000)  return 4;
            return 5;
        end
        return 2;
    endfunction

    // A transaction seen on one edge joins the queue one edge later if there is room.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cap_vld = 1'b0;
            m_ovf = 0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_cap_vld) begin
                if (mq.size() < DEPTH) mq.push_back(m_cap);
                else if (m_ovf < 255) m_ovf++;
            end
            m_cap_vld = in_valid;
            m_cap = '{a: a, b: b, op: operation_select, r: result};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit v, input logic [31:0] ia, input logic [31:0] ib,
                       input bit iop, input logic [31:0] ir);
        in_valid = v; a = ia; b = ib; operation_select = iop; result = ir;
    endtask

    task automatic drv_rand(input bit v);
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 0) r[30:23] = 8'h00;
        if (sel == 1) r[30:23] = 8'hff;
        drv(v, $urandom, $urandom, 1'($urandom_range(0, 1)), r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drv(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        drv(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0d want 0", fifo_full); end
        checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
        checks++; if (out_result !== 32'h0 || out_a !== 32'h0 || out_b !== 32'h0 || out_op !== 1'b0)
            begin errors++; $display("FAIL reset_data: got res=%h a=%h b=%h op=%0d want all 0", out_result, out_a, out_b, out_op); end
        checks++; if (result_class !== 3'd0 || exp_result !== 8'd0 || mantissa_result !== 23'd0 || sign_result !== 1'b0)
            begin errors++; $display("FAIL reset_fields: got cls=%0d exp=%h mant=%h s=%0d want 0", result_class, exp_result, mantissa_result, sign_result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        tick();
        drv(1'b1, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
        tick();
        drv(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got out_valid=%0d at N+1 want 0", out_valid); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0d at N+2 want 1", out_valid); end
        checks++; if (result_class !== 3'd2) begin errors++; $display("FAIL basic_class: got %0d want 2", result_class); end
        checks++; if (sign_result !== 1'b0 || exp_result !== 8'h80 || mantissa_result !== 23'd0)
            begin errors++; $display("FAIL basic_fields: got s=%0d exp=%h mant=%h want 0/80/0", sign_result, exp_result, mantissa_result); end
        checks++; if (out_a !== 32'h3f800000 || out_b !== 32'h3f800000 || out_result !== 32'h40000000 || out_op !== 1'b0)
            begin errors++; $display("FAIL basic_data: got a=%h b=%h r=%h op=%0d", out_a, out_b, out_result, out_op); end
        drain();
    endtask

    task automatic test_classes();
        logic [31:0] rv [5];
        int          ec [5];
        bit          es [5];
        rv = '{32'h7fc00000, 32'h7f800001, 32'hff800000, 32'h00000001, 32'h80000000};
        ec = '{4, 5, 3, 1, 0};
        es = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        tick();
        drv(1'b1, $urandom, $urandom, 1'b1, rv[0]);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 5) drv(1'b1, $urandom, $urandom, 1'b1, rv[i]);
            else       drv(1'b0, '0, '0, 1'b0, '0);
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== rv[i-2] || int'(result_class) != ec[i-2] || sign_result !== es[i-2]) begin
                    errors++;
                    $display("FAIL class_seq[%0d]: got v=%0d r=%h cls=%0d s=%0d want v=1 r=%h cls=%0d s=%0d",
                             i-2, out_valid, out_result, result_class, sign_result, rv[i-2], ec[i-2], es[i-2]);
                end
            end
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [31:0] sa [6];
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            drv_rand(1'b1);
            sa[i] = a;
        end
        tick();
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (3) tick();
        checks++; if (fifo_full !== 1'b1 || fifo_count !== 3'd4)
            begin errors++; $display("FAIL ovf_full: got full=%0d count=%0d want 1/4", fifo_full, fifo_count); end
        checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL ovf_count: got %0d want 2", overflow_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_a !== sa[k])
                begin errors++; $display("FAIL ovf_order[%0d]: got v=%0d a=%h want 1/%h", k, out_valid, out_a, sa[k]); end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_a !== 32'h0)
            begin errors++; $display("FAIL ovf_empty: got v=%0d a=%h want 0/0", out_valid, out_a); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            drv_rand(1'b1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            drv_rand(1'b1);
            @(negedge clk);
            checks++;
            if (fifo_count !== 3'd4 || overflow_cnt !== 8'd1)
                begin errors++; $display("FAIL b2b_level[%0d]: got count=%0d ovf=%0d want 4/1", k, fifo_count, overflow_cnt); end
            checks++;
            if (mq.size() == 0 || out_a !== mq[0].a || out_result !== mq[0].r)
                begin errors++; $display("FAIL b2b_head[%0d]: got a=%h r=%h want model head", k, out_a, out_result); end
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [31:0] fa;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            drv_rand(1'b1);
        end
        tick();
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd3 || overflow_cnt !== 8'd1)
            begin errors++; $display("FAIL arst_pre: got count=%0d ovf=%0d want 3/1", fifo_count, overflow_cnt); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0 || overflow_cnt !== 8'd0 || fifo_full !== 1'b0)
            begin errors++; $display("FAIL arst_clear: got count=%0d v=%0d ovf=%0d full=%0d want 0", fifo_count, out_valid, overflow_cnt, fifo_full); end
        checks++; if (out_a !== 32'h0 || out_result !== 32'h0)
            begin errors++; $display("FAIL arst_data: got a=%h r=%h want 0", out_a, out_result); end
        #1 rst_n = 1'b1;
        tick();
        drv_rand(1'b1);
        fa = a;
        tick();
        drv(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_lat_early: got %0d want 0", out_valid); end
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_a !== fa)
            begin errors++; $display("FAIL arst_lat: got v=%0d a=%h want 1/%h", out_valid, out_a, fa); end
        drain();
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 305; i++) begin
            tick();
            drv_rand(1'b1);
        end
        tick();
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (3) tick();
        checks++; if (overflow_cnt !== 8'd255) begin errors++; $display("FAIL sat_ovf: got %0d want 255", overflow_cnt); end
        checks++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1)
            begin errors++; $display("FAIL sat_level: got count=%0d full=%0d want 4/1", fifo_count, fifo_full); end
        drain();
    endtask

    task automatic test_random();
        int exp_cls;
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            tick();
            drv_rand($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            checks++;
            if (int'(fifo_count) != mq.size() || out_valid !== (mq.size() > 0) ||
                fifo_full !== (mq.size() == DEPTH) || int'(overflow_cnt) != m_ovf) begin
                errors++;
                $display("FAIL rand_state[%0d]: got count=%0d v=%0d full=%0d ovf=%0d want count=%0d ovf=%0d",
                         c, fifo_count, out_valid, fifo_full, overflow_cnt, mq.size(), m_ovf);
            end
            if (mq.size() > 0) begin
                exp_cls = cls_of(mq[0].r);
                checks++;
                if (out_a !== mq[0].a || out_b !== mq[0].b || out_op !== mq[0].op || out_result !== mq[0].r ||
                    int'(result_class) != exp_cls || sign_result !== mq[0].r[31] ||
                    32'(exp_result) != ((mq[0].r >> 23) & 32'hff) || 32'(mantissa_result) != (mq[0].r & 32'h7fffff)) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got a=%h b=%h op=%0d r=%h cls=%0d want a=%h b=%h op=%0d r=%h cls=%0d",
                             c, out_a, out_b, out_op, out_result, result_class,
                             mq[0].a, mq[0].b, mq[0].op, mq[0].r, exp_cls);
                end
            end else begin
                checks++;
                if (out_result !== 32'h0 || out_a !== 32'h0 || result_class !== 3'd0)
                    begin errors++; $display("FAIL rand_empty[%0d]: got r=%h a=%h cls=%0d want 0", c, out_result, out_a, result_class); end
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_classes();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
